// File: rtl/u_seqdiv16_8_pkg.sv
// ---------------------------------------------------------------------------
// u_seqdiv16_8_pkg
// Shared definitions for the sequential restoring divider.
//   N         : default divisor / remainder width (dividend and quotient are 2N)
//   CNT_W     : width of the step counter, clog2(2N)
//   state_t   : control FSM states IDLE / BUSY / DONE
//   cnt_width : counter width for an arbitrary N (used when N is overridden)
// ---------------------------------------------------------------------------
package u_seqdiv16_8_pkg;

  localparam int N     = 8;
  localparam int CNT_W = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bits needed to count 2n-1 down to 0.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/u_seqdiv16_8_csub_step.sv
// ---------------------------------------------------------------------------
// Conditional-subtract step of the restoring divider, plus its leaf cells.
//
// fa        : full adder   (i_a, i_b, i_c) -> (o_s, o_co)
// ha        : half adder   (i_a, i_b)      -> (o_s, o_c)
// csub_step : one restoring step on an (N+1)-bit shifted partial remainder
//   i_pr      [N:0]   shifted partial remainder {pr, next dividend bit}
//   i_divisor [N-1:0] divisor
//   o_pr      [N-1:0] restored / reduced partial remainder
//   o_qbit            quotient bit (1 when i_pr >= i_divisor)
//
// The subtractor computes i_pr + ~{1'b0, i_divisor} + 1 with a ripple chain.
// A final carry of 1 means "no borrow", i.e. i_pr >= i_divisor.
// ---------------------------------------------------------------------------
module fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module csub_step
  import u_seqdiv16_8_pkg::*;
#(
  parameter int N = u_seqdiv16_8_pkg::N
) (
  input  logic [N:0]   i_pr,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_pr,
  output logic         o_qbit
);

  logic [N:0]   w_carry;
  logic [N-1:0] w_diff;
  logic         w_top_s;
  logic         w_top_c;
  logic         w_no_borrow;

  // Carry-in of 1 completes the two's complement of the divisor.
  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      fa u_fa (
        .i_a  (i_pr[gi]),
        .i_b  (~i_divisor[gi]),
        .i_c  (w_carry[gi]),
        .o_s  (w_diff[gi]),
        .o_co (w_carry[gi+1])
      );
    end
  endgenerate

  // The top divisor bit is an implicit 0, so its complement is 1:
  // i_pr[N] + 1 + carry. Carry-out of that sum is (a^c) | (a&c). The sum bit
  // itself is not needed: a successful subtraction always leaves a value
  // below the divisor, which fits in N bits.
  ha u_ha (
    .i_a (i_pr[N]),
    .i_b (w_carry[N]),
    .o_s (w_top_s),
    .o_c (w_top_c)
  );

  assign w_no_borrow = w_top_s | w_top_c;

  // Restoring mux: keep the difference only when it did not go negative.
  always_comb begin
    o_qbit = w_no_borrow;
    if (w_no_borrow) begin
      o_pr = w_diff;
    end else begin
      o_pr = i_pr[N-1:0];
    end
  end

endmodule

// File: rtl/u_seqdiv16_8.sv
// ---------------------------------------------------------------------------
// u_seqdiv16_8 -- sequential restoring divider, 2N-bit dividend / N-bit divisor
//
// One quotient bit per BUSY cycle, MSB first; 2N BUSY cycles per division.
// Divide-by-zero bypasses BUSY and reports quotient all-ones,
// remainder = dividend[N-1:0], dbz = 1.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operands valid          in_ready  : accepting (state IDLE)
//   dividend   : [2N-1:0] unsigned        divisor   : [N-1:0] unsigned
//   out_valid  : result valid (DONE)     out_ready : consumer takes result
//   quotient   : [2N-1:0]                remainder : [N-1:0]
//   dbz        : divide-by-zero flag, qualified by out_valid
// ---------------------------------------------------------------------------
module u_seqdiv16_8
  import u_seqdiv16_8_pkg::*;
#(
  parameter int N = u_seqdiv16_8_pkg::N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           dbz
);

  localparam int DW = 2 * N;
  localparam int CW = cnt_width(N);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_dividend;
  logic [N-1:0]  r_divisor;
  logic [N-1:0]  r_pr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_quot;
  logic [N-1:0]  r_rem;
  logic          r_dbz;

  logic          w_accept;
  logic          w_div_zero;
  logic          w_last_step;
  logic          w_retire;
  logic [N:0]    w_pr_shift;
  logic [N-1:0]  w_pr_step;
  logic          w_qbit;

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_div_zero  = (divisor == '0);
  assign w_last_step = (r_cnt == '0);
  assign w_retire    = (r_state == DONE) && out_ready;

  // The counter doubles as the dividend bit index: it starts at 2N-1, so the
  // MSB is shifted in first and bit 0 on the final step.
  assign w_pr_shift = {r_pr, r_dividend[r_cnt]};

  csub_step #(
    .N (N)
  ) u_csub (
    .i_pr      (w_pr_shift),
    .i_divisor (r_divisor),
    .o_pr      (w_pr_step),
    .o_qbit    (w_qbit)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_div_zero) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = BUSY;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (w_last_step) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        // Retiring returns to IDLE; a new accept can only follow a cycle later.
        if (w_retire) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs and result port drive (all sourced from registers).
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    quotient  = r_quot;
    remainder = r_rem;
    dbz       = r_dbz;
  end

  // Datapath: operand capture, one restoring step per BUSY cycle, result hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_pr       <= '0;
      r_cnt      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_pr       <= '0;
            r_cnt      <= CW'(DW - 1);
            if (w_div_zero) begin
              r_quot <= '1;
              r_rem  <= dividend[N-1:0];
              r_dbz  <= 1'b1;
            end else begin
              r_quot <= '0;
              r_rem  <= '0;
              r_dbz  <= 1'b0;
            end
          end else begin
            r_pr <= r_pr;
          end
        end
        BUSY: begin
          r_pr   <= w_pr_step;
          r_quot <= {r_quot[DW-2:0], w_qbit};
          r_cnt  <= r_cnt - CW'(1);
          if (w_last_step) begin
            r_rem <= w_pr_step;
          end else begin
            r_rem <= r_rem;
          end
        end
        DONE: begin
          // Results are held until retirement.
          r_rem <= r_rem;
        end
        default: begin
          r_pr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_u_seqdiv16_8.sv
// ---------------------------------------------------------------------------
// Testbench for u_seqdiv16_8 (N = 8).
// A timeline model predicts, from the handshakes the bench drives, when the
// block is ready, when a result appears, and what it must be (plain / and %).
// A negedge compare process checks the DUT against that model every cycle;
// directed operations additionally pin literal results and latencies.
// ---------------------------------------------------------------------------
module tb_u_seqdiv16_8;

  localparam int NOPS = 2500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state.
  bit          m_idle    = 1'b1;
  bit          m_valid   = 1'b0;
  int          m_wait    = 0;
  logic [15:0] m_a       = 16'h0000;
  logic [7:0]  m_b       = 8'h00;
  logic [15:0] m_q       = 16'h0000;
  logic [7:0]  m_r       = 8'h00;
  logic        m_dbz     = 1'b0;
  int          m_acc_cnt = 0;

  u_seqdiv16_8 #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Model: a result appears 16 edges after an accept (at the accept edge for
  // a zero divisor) and leaves on the first edge with out_ready high.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle    <= 1'b0;
        m_a       <= dividend;
        m_b       <= divisor;
        m_acc_cnt <= m_acc_cnt + 1;
        if (divisor == 8'h00) begin
          m_valid <= 1'b1;
          m_q     <= 16'hFFFF;
          m_r     <= dividend[7:0];
          m_dbz   <= 1'b1;
        end else begin
          m_wait  <= 16;
          m_q     <= dividend / {8'h00, divisor};
          m_r     <= 8'(dividend % {8'h00, divisor});
          m_dbz   <= 1'b0;
        end
      end
    end else if (!m_valid) begin
      if (m_wait == 1) m_valid <= 1'b1;
      m_wait <= m_wait - 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_idle));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("quotient", 32'(quotient), 32'(m_q));
        chk("remainder", 32'(remainder), 32'(m_r));
        chk("dbz", 32'(dbz), 32'(m_dbz));
        if (!m_dbz) begin
          chk("identity", 32'(quotient) * 32'(m_b) + 32'(remainder), 32'(m_a));
          chk("rem_lt_div", 32'(remainder < m_b), 32'd1);
        end
      end
    end
  end

  // One directed operation with literal expectations. hold = cycles to keep
  // out_ready low once the result is up (0: out_ready high from the start).
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er,
                       input logic edbz, input int elat, input int hold);
    int n;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_op", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    // Junk on the operand inputs while not idle must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(elat));
    in_valid = 1'b0;
    chk("lit_quotient", 32'(quotient), 32'(eq));
    chk("lit_remainder", 32'(remainder), 32'(er));
    chk("lit_dbz", 32'(dbz), 32'(edbz));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_quotient", 32'(quotient), 32'(eq));
      chk("hold_remainder", 32'(remainder), 32'(er));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("retired", 32'(out_valid), 32'd0);
    chk("idle_after_retire", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int start;
    int cycles;
    int sel;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'h0000;
    divisor   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    do_op(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16, 0);
    do_op(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16, 0);
    do_op(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16, 0);
    do_op(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 0, 0);
    do_op(16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 16, 10);
    do_op(16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 16, 0);
    do_op(16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 16, 0);
    do_op(16'h00FF, 8'h00, 16'hFFFF, 8'hFF, 1'b1, 0, 3);

    // Abort a division part way through BUSY.
    in_valid = 1'b1;
    dividend = 16'hBEEF;
    divisor  = 8'h13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("no_stale_valid", 32'(out_valid), 32'd0);
    end
    do_op(16'h0009, 8'h02, 16'h0004, 8'h01, 1'b0, 16, 0);

    // Randomized operands, randomized in_valid and out_ready.
    start  = m_acc_cnt;
    cycles = 0;
    while ((m_acc_cnt - start) < NOPS && cycles < 80000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 15);
      case (sel)
        0:       dividend = 16'h0000;
        1:       dividend = 16'hFFFF;
        default: dividend = 16'($urandom);
      endcase
      sel = $urandom_range(0, 15);
      case (sel)
        0:       divisor = 8'h00;
        1:       divisor = 8'h01;
        2:       divisor = 8'hFF;
        default: divisor = 8'($urandom_range(1, 255));
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cycles++;
    end
    chk("random_ops_done", 32'((m_acc_cnt - start) >= NOPS), 32'd1);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drained_idle", 32'(in_ready), 32'd1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
